// File: rtl/display_siete_segmentos.sv
// Three-digit signed decimal display driver for a 4-digit multiplexed
// seven-segment module. Converts a signed byte to sign + BCD with a
// sequential double-dabble, then scans the digits on each clk_dividido tick.
module display_siete_segmentos #(
  parameter int unsigned SUPRIMIR_CEROS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_dividido,
  input  logic       dato_valido,
  input  logic [7:0] dato,
  output logic       ocupado,
  output logic [3:0] anodos,
  output logic [6:0] segmentos
);

  localparam int unsigned ANCHO_DATO = 8;
  localparam int unsigned ANCHO_BCD  = 12;
  localparam int unsigned ANCHO_DESP = ANCHO_BCD + ANCHO_DATO;
  localparam int unsigned NUM_BCD    = 3;
  localparam bit          SUPRIMIR   = (SUPRIMIR_CEROS != 0);

  localparam logic [1:0] INACTIVO  = 2'd0;
  localparam logic [1:0] ABSOLUTO  = 2'd1;
  localparam logic [1:0] DESPLAZA  = 2'd2;
  localparam logic [1:0] ACTUALIZA = 2'd3;

  localparam logic [2:0] ULTIMO_PASO = 3'd7;

  // Active-low segment codes, bit6..bit0 = a..g
  localparam logic [6:0] SEG_0      = 7'b0000001;
  localparam logic [6:0] SEG_1      = 7'b1001111;
  localparam logic [6:0] SEG_2      = 7'b0010010;
  localparam logic [6:0] SEG_3      = 7'b0000110;
  localparam logic [6:0] SEG_4      = 7'b1001100;
  localparam logic [6:0] SEG_5      = 7'b0100100;
  localparam logic [6:0] SEG_6      = 7'b0100000;
  localparam logic [6:0] SEG_7      = 7'b0001111;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0000100;
  localparam logic [6:0] SEG_BLANCO = 7'b1111111;
  localparam logic [6:0] SEG_MENOS  = 7'b1111110;

  logic [1:0]            estado_q, estado_d;
  logic [ANCHO_DATO-1:0] dato_q;
  logic [ANCHO_DATO-1:0] magnitud_c;
  logic [ANCHO_DESP-1:0] desp_q;
  logic [ANCHO_DESP-1:0] ajustado_c;
  logic [ANCHO_DESP-1:0] paso_c;
  logic [2:0]            paso_q;
  logic [3:0]            centenas_q, decenas_q, unidades_q;
  logic                  negativo_q;
  logic                  clk_div_q;
  logic                  tick_c;
  logic [1:0]            indice_q;
  logic [3:0]            anodo_c;
  logic [6:0]            seg_c;

  function automatic logic [6:0] decodifica(input logic [3:0] d);
    case (d)
      4'd0:    decodifica = SEG_0;
      4'd1:    decodifica = SEG_1;
      4'd2:    decodifica = SEG_2;
      4'd3:    decodifica = SEG_3;
      4'd4:    decodifica = SEG_4;
      4'd5:    decodifica = SEG_5;
      4'd6:    decodifica = SEG_6;
      4'd7:    decodifica = SEG_7;
      4'd8:    decodifica = SEG_8;
      4'd9:    decodifica = SEG_9;
      default: decodifica = SEG_BLANCO;
    endcase
  endfunction

  // Rising-edge detect of the scan-rate level
  assign tick_c = clk_dividido & ~clk_div_q;

  // Unsigned magnitude; -128 wraps to 0x80, which is the correct magnitude
  assign magnitud_c = dato_q[ANCHO_DATO-1] ? (~dato_q + 8'd1) : dato_q;

  // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left
  always_comb begin
    ajustado_c = desp_q;
    for (int i = 0; i < NUM_BCD; i++) begin
      if (desp_q[ANCHO_DATO + 4*i +: 4] >= 4'd5) begin
        ajustado_c[ANCHO_DATO + 4*i +: 4] = desp_q[ANCHO_DATO + 4*i +: 4] + 4'd3;
      end
    end
    paso_c = ajustado_c << 1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= INACTIVO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INACTIVO:  if (dato_valido) estado_d = ABSOLUTO;
      ABSOLUTO:  estado_d = DESPLAZA;
      DESPLAZA:  if (paso_q == ULTIMO_PASO) estado_d = ACTUALIZA;
      default:   estado_d = INACTIVO;
    endcase
  end

  // Busy flag, registered from the next state so it tracks state != INACTIVO
  always_ff @(posedge clk) begin
    if (reset) begin
      ocupado <= 1'b0;
    end else begin
      ocupado <= (estado_d != INACTIVO);
    end
  end

  // Capture, magnitude load and shift datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_q <= '0;
      desp_q <= '0;
      paso_q <= '0;
    end else begin
      case (estado_q)
        INACTIVO: if (dato_valido) dato_q <= dato;
        ABSOLUTO: begin
          desp_q <= {ANCHO_BCD'(0), magnitud_c};
          paso_q <= '0;
        end
        DESPLAZA: begin
          desp_q <= paso_c;
          paso_q <= paso_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Display registers, updated only when a conversion completes
  always_ff @(posedge clk) begin
    if (reset) begin
      centenas_q <= '0;
      decenas_q  <= '0;
      unidades_q <= '0;
      negativo_q <= 1'b0;
    end else if (estado_q == ACTUALIZA) begin
      centenas_q <= desp_q[ANCHO_DATO + 8 +: 4];
      decenas_q  <= desp_q[ANCHO_DATO + 4 +: 4];
      unidades_q <= desp_q[ANCHO_DATO +: 4];
      negativo_q <= dato_q[ANCHO_DATO-1];
    end
  end

  // Digit select and leading-zero blanking for the current scan position
  always_comb begin
    anodo_c = 4'b1111;
    seg_c   = SEG_BLANCO;
    case (indice_q)
      2'd0: begin
        anodo_c = 4'b1110;
        seg_c   = decodifica(unidades_q);
      end
      2'd1: begin
        anodo_c = 4'b1101;
        seg_c   = (SUPRIMIR && centenas_q == 4'd0 && decenas_q == 4'd0)
                  ? SEG_BLANCO : decodifica(decenas_q);
      end
      2'd2: begin
        anodo_c = 4'b1011;
        seg_c   = (SUPRIMIR && centenas_q == 4'd0) ? SEG_BLANCO : decodifica(centenas_q);
      end
      default: begin
        anodo_c = 4'b0111;
        seg_c   = negativo_q ? SEG_MENOS : SEG_BLANCO;
      end
    endcase
  end

  // Scan: outputs and digit index move only on a tick
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_div_q <= 1'b0;
      indice_q  <= '0;
      anodos    <= 4'b1111;
      segmentos <= SEG_BLANCO;
    end else begin
      clk_div_q <= clk_dividido;
      if (tick_c) begin
        indice_q  <= indice_q + 2'd1;
        anodos    <= anodo_c;
        segmentos <= seg_c;
      end
    end
  end

endmodule

// File: tb/tb_display_siete_segmentos.sv
// Directed bench for display_siete_segmentos: one instance with leading-zero
// blanking and one without, driven from the same stimulus.
module tb_display_siete_segmentos;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S4  = 7'b1001100;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S6  = 7'b0100000;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0000100;
  localparam logic [6:0] SBL = 7'b1111111;
  localparam logic [6:0] SMI = 7'b1111110;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_dividido;
  logic       dato_valido;
  logic [7:0] dato;
  logic       ocupado, ocupado_nz;
  logic [3:0] anodos, anodos_nz;
  logic [6:0] segmentos, segmentos_nz;

  int errors = 0;
  int checks = 0;
  logic [1:0] idx;

  typedef struct {
    logic [7:0] dato;
    logic [6:0] uni;
    logic [6:0] dec;
    logic [6:0] cen;
    logic [6:0] sig;
    logic [6:0] dec_nz;
    logic [6:0] cen_nz;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  display_siete_segmentos #(.SUPRIMIR_CEROS(1)) dut (
    .clk(clk), .reset(reset), .clk_dividido(clk_dividido),
    .dato_valido(dato_valido), .dato(dato),
    .ocupado(ocupado), .anodos(anodos), .segmentos(segmentos)
  );

  display_siete_segmentos #(.SUPRIMIR_CEROS(0)) dut_nz (
    .clk(clk), .reset(reset), .clk_dividido(clk_dividido),
    .dato_valido(dato_valido), .dato(dato),
    .ocupado(ocupado_nz), .anodos(anodos_nz), .segmentos(segmentos_nz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Four ticks, checking each scanned digit on both instances
  task automatic scan_check(input string tag,
                            input logic [6:0] e_uni, input logic [6:0] e_dec,
                            input logic [6:0] e_cen, input logic [6:0] e_sig,
                            input logic [6:0] e_dec_nz, input logic [6:0] e_cen_nz);
    logic [3:0] ea;
    logic [6:0] e, enz;
    for (int k = 0; k < 4; k++) begin
      clk_dividido = 1'b1;
      step();
      case (idx)
        2'd0:    begin ea = 4'b1110; e = e_uni; enz = e_uni;    end
        2'd1:    begin ea = 4'b1101; e = e_dec; enz = e_dec_nz; end
        2'd2:    begin ea = 4'b1011; e = e_cen; enz = e_cen_nz; end
        default: begin ea = 4'b0111; e = e_sig; enz = e_sig;    end
      endcase
      chk($sformatf("%s d%0d anodos", tag, idx), 32'(anodos), 32'(ea));
      chk($sformatf("%s d%0d segmentos", tag, idx), 32'(segmentos), 32'(e));
      chk($sformatf("%s d%0d anodos_nz", tag, idx), 32'(anodos_nz), 32'(ea));
      chk($sformatf("%s d%0d segmentos_nz", tag, idx), 32'(segmentos_nz), 32'(enz));
      idx = idx + 2'd1;
      clk_dividido = 1'b0;
      step();
    end
  endtask

  // One-cycle dato_valido pulse, then busy high for 10 cycles and low on the 11th
  task automatic convertir(input string tag, input logic [7:0] v);
    dato = v;
    dato_valido = 1'b1;
    step();
    dato_valido = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("%s ocupado c%0d", tag, k), 32'(ocupado), 32'd1);
      chk($sformatf("%s ocupado_nz c%0d", tag, k), 32'(ocupado_nz), 32'd1);
      step();
    end
    chk($sformatf("%s ocupado c11", tag), 32'(ocupado), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h7F, S7, S2, S1, SBL, S2, S1};
    vecs[1]  = '{8'h80, S8, S2, S1, SMI, S2, S1};
    vecs[2]  = '{8'hF6, S0, S1, SBL, SMI, S1, S0};
    vecs[3]  = '{8'h00, S0, SBL, SBL, SBL, S0, S0};
    vecs[4]  = '{8'hFF, S1, SBL, SBL, SMI, S0, S0};
    vecs[5]  = '{8'h64, S0, S0, S1, SBL, S0, S1};
    vecs[6]  = '{8'h9C, S0, S0, S1, SMI, S0, S1};
    vecs[7]  = '{8'h2D, S5, S4, SBL, SBL, S4, S0};
    vecs[8]  = '{8'h81, S7, S2, S1, SMI, S2, S1};
    vecs[9]  = '{8'h09, S9, SBL, SBL, SBL, S0, S0};
    vecs[10] = '{8'h3E, S2, S6, SBL, SBL, S6, S0};
    vecs[11] = '{8'hDD, S5, S3, SBL, SMI, S3, S0};

    reset = 1'b1;
    clk_dividido = 1'b0;
    dato_valido = 1'b0;
    dato = 8'h00;
    idx = 2'd0;
    repeat (3) step();

    // Reset state
    chk("reset ocupado", 32'(ocupado), 32'd0);
    chk("reset anodos", 32'(anodos), 32'hF);
    chk("reset segmentos", 32'(segmentos), 32'(SBL));
    reset = 1'b0;
    repeat (3) step();
    chk("pre-tick anodos", 32'(anodos), 32'hF);
    chk("pre-tick segmentos", 32'(segmentos), 32'(SBL));

    // First ticks after reset show positive zero
    scan_check("post-reset", S0, SBL, SBL, SBL, S0, S0);

    // Table of conversions
    for (int i = 0; i < NV; i++) begin
      convertir($sformatf("vec%0d", i), vecs[i].dato);
      scan_check($sformatf("vec%0d", i), vecs[i].uni, vecs[i].dec, vecs[i].cen,
                 vecs[i].sig, vecs[i].dec_nz, vecs[i].cen_nz);
    end

    // Request while busy is dropped
    dato = 8'h05;
    dato_valido = 1'b1;
    step();
    dato_valido = 1'b0;
    repeat (3) step();
    dato = 8'h63;
    dato_valido = 1'b1;
    step();
    dato_valido = 1'b0;
    repeat (6) step();
    chk("ignore ocupado c11", 32'(ocupado), 32'd0);
    step();
    chk("ignore ocupado c12", 32'(ocupado), 32'd0);
    scan_check("ignore", S5, SBL, SBL, SBL, S0, S0);

    // dato_valido held: re-accepted on the first idle cycle
    dato = 8'h64;
    dato_valido = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("held ocupado c%0d", k), 32'(ocupado), 32'd1);
      step();
    end
    chk("held ocupado c11", 32'(ocupado), 32'd0);
    step();
    dato_valido = 1'b0;
    chk("held ocupado c12", 32'(ocupado), 32'd1);
    repeat (10) step();
    chk("held ocupado c22", 32'(ocupado), 32'd0);
    scan_check("held", S0, S0, S1, SBL, S0, S1);

    // Tick coinciding with ACTUALIZA scans the old value (100 -> 127)
    dato = 8'h7F;
    dato_valido = 1'b1;
    step();
    dato_valido = 1'b0;
    repeat (9) step();
    chk("coinc in ACTUALIZA", 32'(ocupado), 32'd1);
    clk_dividido = 1'b1;
    step();
    chk("coinc anodos", 32'(anodos), 32'hE);
    chk("coinc old units", 32'(segmentos), 32'(S0));
    chk("coinc ocupado", 32'(ocupado), 32'd0);
    idx = idx + 2'd1;
    clk_dividido = 1'b0;
    step();
    scan_check("coinc new", S7, S2, S1, SBL, S2, S1);

    // Reset in the middle of a conversion
    dato = 8'h80;
    dato_valido = 1'b1;
    step();
    dato_valido = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idx = 2'd0;
    chk("midreset ocupado", 32'(ocupado), 32'd0);
    chk("midreset anodos", 32'(anodos), 32'hF);
    chk("midreset segmentos", 32'(segmentos), 32'(SBL));
    chk("midreset segmentos_nz", 32'(segmentos_nz), 32'(SBL));
    repeat (8) begin
      chk("midreset stays idle", 32'(ocupado), 32'd0);
      step();
    end
    scan_check("midreset", S0, SBL, SBL, SBL, S0, S0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_siete_segmentos.md
DISPLAY_SIETE_SEGMENTOS -- requirements
Module: display_siete_segmentos

Interface
REQ-001 Parameter: SUPRIMIR_CEROS, default 1, 1 = blank leading zero digits, 0 = show all three decimal digits.
REQ-002 clk  input  1  system clock (100 MHz); the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_dividido  input  1  10 kHz square-wave level from the upstream clock divider, sampled in the clk domain, never used as a clock.
REQ-005 dato_valido  input  1  request to load dato.
REQ-006 dato  input  8  two's-complement signed product, -128..127.
REQ-007 ocupado  output  1  high while a conversion is in progress.
REQ-008 anodos  output  4  active-low one-hot digit enables: [0] units, [1] tens, [2] hundreds, [3] sign.
REQ-009 segmentos  output  7  active-low segments, bit6..bit0 = a,b,c,d,e,f,g.

Function
REQ-010 A scan tick is generated for one clk cycle on each rising edge of clk_dividido (current sample 1, previous registered sample 0).
REQ-011 FSM states: INACTIVO, ABSOLUTO, DESPLAZA, ACTUALIZA; ocupado = (state != INACTIVO).
REQ-012 dato is accepted only on a cycle with state INACTIVO and dato_valido = 1; dato and its sign bit are captured, and the next state is ABSOLUTO.
REQ-013 dato_valido while ocupado = 1 is ignored; no queuing.
REQ-014 ABSOLUTO lasts 1 cycle and forms the 8-bit unsigned magnitude; -128 gives 128 (0x80).
REQ-015 DESPLAZA lasts exactly 8 cycles, performing a double-dabble step each cycle.
- Each step adds 3 to any BCD nibble >= 5, then shifts left 1.
- Produces 3 BCD digits (centenas, decenas, unidades).
REQ-016 ACTUALIZA lasts 1 cycle, copies the BCD digits and sign into the display registers, then returns to INACTIVO.
REQ-017 Timing for acceptance at edge N: ocupado is high for cycles N+1..N+10 and low at N+11; new display registers are valid from N+11.
REQ-018 dato_valido held high re-accepts on every INACTIVO cycle, giving one conversion per 11 cycles.
REQ-019 A 2-bit digit index advances on each scan tick, 0->1->2->3->0 with wrap; anodos and segmentos are registered and change only on the cycle after a tick.
REQ-020 Active-low digit codes (abcdefg):
- 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100
- 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100
- blank 1111111, minus 1111110.
REQ-021 Sign digit (index 3) shows minus when the captured value is negative, otherwise blank.
REQ-022 With SUPRIMIR_CEROS = 1, leading zeros are blanked:
- Hundreds is blank when 0.
- Tens is blank when hundreds and tens are both 0.
- Units is always shown.
REQ-023 When a tick and ACTUALIZA occur in the same cycle, that scan uses the old display registers; the new value appears from the following tick.

Reset
REQ-024 Reset values:
- state INACTIVO, ocupado 0, digit index 0, edge-detect register 0.
- Display registers hold positive zero.
- anodos 1111, segmentos 1111111.
REQ-025 Reset asserted in any state, including mid-DESPLAZA, aborts the conversion; the next-cycle outputs equal the REQ-024 values.
REQ-026 After reset, outputs stay blank until the first scan tick.

Verification
REQ-027 Reset, then one clk_dividido rising edge -> next cycle anodos 1110, segmentos 0000001; remaining digits blank on later ticks.
REQ-028 dato 0x7F with a one-cycle dato_valido -> ocupado high exactly 10 cycles; over 4 ticks the digits are units 0001111, tens 0010010, hundreds 1001111, sign 1111111.
REQ-029 dato 0x80 -> units 0000000, tens 0010010, hundreds 1001111, sign 1111110.
REQ-030 dato 0xF6 (-10) with SUPRIMIR_CEROS = 1 -> units 0000001, tens 1001111, hundreds 1111111, sign 1111110; with SUPRIMIR_CEROS = 0 hundreds shows 0000001.
REQ-031 Accept 0x05, then pulse dato_valido with 0x63 at cycle N+4 -> 0x63 is ignored and the display shows 5 (0100100), with tens and hundreds blank.
REQ-032 Assert reset at cycle N+5 of a conversion -> next cycle ocupado 0, anodos 1111, segmentos 1111111; the next tick shows 0.
